// File: rtl/spram32_arb.sv
// spram32_arb: round-robin arbiter sharing one 32-bit SPRAM port between two
// requesters. It allows bounded bursts and routes the one-cycle read data back
// to the requester that issued the read.
module spram32_arb #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [14:0] ai0,
    input  logic [14:0] ai1,
    input  logic [31:0] vi0,
    input  logic [31:0] vi1,
    input  logic [3:0]  bmsk0,
    input  logic [3:0]  bmsk1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] vo0,
    output logic [31:0] vo1,
    output logic [14:0] mem_ai,
    output logic [31:0] mem_vi,
    output logic        mem_we,
    output logic [3:0]  mem_bmsk,
    input  logic [31:0] mem_vo
);

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_R0   = 2'd1,
        SEL_R1   = 2'd2
    } sel_t;

    sel_t          owner_q, owner_d;
    sel_t          last_q,  last_d;
    sel_t          rsel_q,  rsel_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    sel_t          dec;
    logic          dec_we;
    logic          owner_req;
    logic          other_req;

    // Arbitration decision: keep the burst owner unless its quota is spent and
    // the other side waits, otherwise round-robin on ties.
    always_comb begin
        dec       = SEL_NONE;
        owner_req = 1'b0;
        other_req = 1'b0;
        case (owner_q)
            SEL_R0: begin
                owner_req = req0;
                other_req = req1;
            end
            SEL_R1: begin
                owner_req = req1;
                other_req = req0;
            end
            default: begin
                owner_req = 1'b0;
                other_req = 1'b0;
            end
        endcase
        if ((owner_q != SEL_NONE) && owner_req && !((cnt_q == CNT_MAX) && other_req)) begin
            dec = owner_q;
        end else if (req0 && req1) begin
            dec = (last_q == SEL_R0) ? SEL_R1 : SEL_R0;
        end else if (req0) begin
            dec = SEL_R0;
        end else if (req1) begin
            dec = SEL_R1;
        end
    end

    // Grants, memory port mux and next-state for owner/last/cnt/rsel.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        mem_ai   = '0;
        mem_vi   = '0;
        mem_we   = 1'b0;
        mem_bmsk = '0;
        dec_we   = 1'b0;
        case (dec)
            SEL_R0: begin
                gnt0     = 1'b1;
                mem_ai   = AW'(ai0);
                mem_vi   = DW'(vi0);
                mem_bmsk = MW'(bmsk0);
                dec_we   = we0;
            end
            SEL_R1: begin
                gnt1     = 1'b1;
                mem_ai   = AW'(ai1);
                mem_vi   = DW'(vi1);
                mem_bmsk = MW'(bmsk1);
                dec_we   = we1;
            end
            default: begin
                dec_we = 1'b0;
            end
        endcase
        // Writes never reach the bank while reset is held.
        mem_we = dec_we & ~rst;

        owner_d = dec;
        last_d  = (dec != SEL_NONE) ? dec : last_q;
        if ((dec != SEL_NONE) && (dec == owner_q)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
        rsel_d = ((dec != SEL_NONE) && !dec_we) ? dec : SEL_NONE;
    end

    // State register; last resets to R1 so R0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= SEL_NONE;
            last_q  <= SEL_R1;
            cnt_q   <= '0;
            rsel_q  <= SEL_NONE;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rsel_q  <= rsel_d;
        end
    end

    // Read return is steered by the registered read destination.
    always_comb begin
        rvalid0 = (rsel_q == SEL_R0);
        rvalid1 = (rsel_q == SEL_R1);
        vo0     = mem_vo;
        vo1     = mem_vo;
    end

endmodule

// File: tb/tb_spram32_arb.sv
// Directed bench for spram32_arb: a BURST_MAX=4 instance driven from a vector
// table, and a BURST_MAX=1 instance driven by a hand-written sequence.
module tb_spram32_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // ---------------- DUT A (BURST_MAX = 4) ----------------
    logic        a_rst, a_req0, a_req1, a_we0, a_we1;
    logic [14:0] a_ai0, a_ai1, a_mem_ai;
    logic [31:0] a_vi0, a_vi1, a_vo0, a_vo1, a_mem_vi, a_mem_vo;
    logic [3:0]  a_bmsk0, a_bmsk1, a_mem_bmsk;
    logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_mem_we;

    spram32_arb #(.BURST_MAX(4)) u_a (
        .clk(clk), .rst(a_rst),
        .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
        .ai0(a_ai0), .ai1(a_ai1), .vi0(a_vi0), .vi1(a_vi1),
        .bmsk0(a_bmsk0), .bmsk1(a_bmsk1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rv0), .rvalid1(a_rv1),
        .vo0(a_vo0), .vo1(a_vo1),
        .mem_ai(a_mem_ai), .mem_vi(a_mem_vi), .mem_we(a_mem_we),
        .mem_bmsk(a_mem_bmsk), .mem_vo(a_mem_vo)
    );

    // ---------------- DUT B (BURST_MAX = 1) ----------------
    logic        b_rst, b_req0, b_req1, b_we0, b_we1;
    logic [14:0] b_ai0, b_ai1, b_mem_ai;
    logic [31:0] b_vi0, b_vi1, b_vo0, b_vo1, b_mem_vi, b_mem_vo;
    logic [3:0]  b_bmsk0, b_bmsk1, b_mem_bmsk;
    logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_mem_we;

    spram32_arb #(.BURST_MAX(1)) u_b (
        .clk(clk), .rst(b_rst),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .ai0(b_ai0), .ai1(b_ai1), .vi0(b_vi0), .vi1(b_vi1),
        .bmsk0(b_bmsk0), .bmsk1(b_bmsk1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rv0), .rvalid1(b_rv1),
        .vo0(b_vo0), .vo1(b_vo1),
        .mem_ai(b_mem_ai), .mem_vi(b_mem_vi), .mem_we(b_mem_we),
        .mem_bmsk(b_mem_bmsk), .mem_vo(b_mem_vo)
    );

    // SPRAM behavioural models: byte-masked write, one-cycle read.
    logic [31:0] mem_a [0:32767];
    logic [31:0] mem_b [0:32767];

    always @(posedge clk) begin
        a_mem_vo <= mem_a[a_mem_ai];
        if (a_mem_we) begin
            for (int i = 0; i < 4; i++)
                if (a_mem_bmsk[i]) mem_a[a_mem_ai][i*8 +: 8] <= a_mem_vi[i*8 +: 8];
        end
    end

    always @(posedge clk) begin
        b_mem_vo <= mem_b[b_mem_ai];
        if (b_mem_we) begin
            for (int i = 0; i < 4; i++)
                if (b_mem_bmsk[i]) mem_b[b_mem_ai][i*8 +: 8] <= b_mem_vi[i*8 +: 8];
        end
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [14:0] a0;
        logic [31:0] d0;
        logic [3:0]  m0;
        logic        r1, w1;
        logic [14:0] a1;
        logic [31:0] d1;
        logic [3:0]  m1;
        logic        eg0, eg1, ev0, ev1, ewe;
        logic [31:0] evo;
    } vec_t;

    function automatic vec_t v(
        input logic rst,
        input logic r0, input logic w0, input logic [14:0] a0, input logic [31:0] d0, input logic [3:0] m0,
        input logic r1, input logic w1, input logic [14:0] a1, input logic [31:0] d1, input logic [3:0] m1,
        input logic eg0, input logic eg1, input logic ev0, input logic ev1, input logic ewe,
        input logic [31:0] evo);
        vec_t t;
        t.rst = rst;
        t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0; t.m0 = m0;
        t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1; t.m1 = m1;
        t.eg0 = eg0; t.eg1 = eg1; t.ev0 = ev0; t.ev1 = ev1; t.ewe = ewe;
        t.evo = evo;
        return t;
    endfunction

    localparam logic [14:0] A5 = 15'h0005;
    localparam logic [14:0] AH = 15'h4010;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] BM = 32'h11BB33DD;

    localparam int unsigned NV = 34;
    vec_t vt [NV];

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end

        //          rst r0 w0 a0  d0             m0    r1 w1 a1  d1 m1  g0 g1 v0 v1 we  vo
        vt[0]  = v(1,  0, 0, 0,  0,             0,    0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0);
        vt[1]  = v(1,  1, 1, A5, 32'hBAD0BAD0,  4'hF, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0,  0);
        vt[2]  = v(0,  1, 0, A5, 0,             0,    0, 0, 0,  0, 0,  1, 0, 0, 0, 0,  0);
        vt[3]  = v(0,  1, 1, A5, DB,            4'hF, 0, 0, 0,  0, 0,  1, 0, 1, 0, 1,  0);
        vt[4]  = v(0,  0, 0, 0,  0,             0,    1, 0, A5, 0, 0,  0, 1, 0, 0, 0,  0);
        vt[5]  = v(0,  0, 0, 0,  0,             0,    0, 0, 0,  0, 0,  0, 0, 0, 1, 0,  DB);
        vt[6]  = v(0,  1, 1, AH, 32'h11223344,  4'hF, 0, 0, 0,  0, 0,  1, 0, 0, 0, 1,  0);
        vt[7]  = v(0,  1, 1, AH, 32'hAABBCCDD,  4'h5, 0, 0, 0,  0, 0,  1, 0, 0, 0, 1,  0);
        vt[8]  = v(0,  0, 0, 0,  0,             0,    1, 0, AH, 0, 0,  0, 1, 0, 0, 0,  0);
        vt[9]  = v(0,  0, 0, 0,  0,             0,    0, 0, 0,  0, 0,  0, 0, 0, 1, 0,  BM);
        // contention: R0 x4, R1 x4, R0 x4
        vt[10] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 0, 0, 0,  0);
        vt[11] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 1, 0, 0,  DB);
        vt[12] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 1, 0, 0,  DB);
        vt[13] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 1, 0, 0,  DB);
        vt[14] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  0, 1, 1, 0, 0,  DB);
        vt[15] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  0, 1, 0, 1, 0,  BM);
        vt[16] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  0, 1, 0, 1, 0,  BM);
        vt[17] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  0, 1, 0, 1, 0,  BM);
        vt[18] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 0, 1, 0,  BM);
        vt[19] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 1, 0, 0,  DB);
        vt[20] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 1, 0, 0,  DB);
        vt[21] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 1, 0, 0,  DB);
        // early release: R1 owns with cnt=1, drops req while R0 waits
        vt[22] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  0, 1, 1, 0, 0,  DB);
        vt[23] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  0, 1, 0, 1, 0,  BM);
        vt[24] = v(0,  1, 0, A5, 0,             0,    0, 0, 0,  0, 0,  1, 0, 0, 1, 0,  BM);
        vt[25] = v(0,  1, 0, A5, 0,             0,    0, 0, 0,  0, 0,  1, 0, 1, 0, 0,  DB);
        vt[26] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 1, 0, 0,  DB);
        vt[27] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  1, 0, 1, 0, 0,  DB);
        vt[28] = v(0,  1, 0, A5, 0,             0,    1, 0, AH, 0, 0,  0, 1, 1, 0, 0,  DB);
        // reset during a granted read drops its rvalid
        vt[29] = v(1,  1, 0, A5, 0,             0,    0, 0, 0,  0, 0,  1, 0, 0, 1, 0,  BM);
        vt[30] = v(0,  0, 0, 0,  0,             0,    0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0);
        // write held during reset must not reach memory
        vt[31] = v(1,  1, 1, AH, 32'hFFFFFFFF,  4'hF, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0,  0);
        vt[32] = v(0,  1, 0, AH, 0,             0,    0, 0, 0,  0, 0,  1, 0, 0, 0, 0,  0);
        vt[33] = v(0,  0, 0, 0,  0,             0,    0, 0, 0,  0, 0,  0, 0, 1, 0, 0,  BM);

        b_rst = 1'b1;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
        b_ai0 = '0; b_ai1 = '0; b_vi0 = '0; b_vi1 = '0; b_bmsk0 = '0; b_bmsk1 = '0;
        a_rst = 1'b1;
        a_req0 = 0; a_req1 = 0; a_we0 = 0; a_we1 = 0;
        a_ai0 = '0; a_ai1 = '0; a_vi0 = '0; a_vi1 = '0; a_bmsk0 = '0; a_bmsk1 = '0;

        @(posedge clk);
        #1;

        // Table phase on DUT A
        for (int i = 0; i < int'(NV); i++) begin
            a_rst = vt[i].rst;
            a_req0 = vt[i].r0; a_we0 = vt[i].w0; a_ai0 = vt[i].a0; a_vi0 = vt[i].d0; a_bmsk0 = vt[i].m0;
            a_req1 = vt[i].r1; a_we1 = vt[i].w1; a_ai1 = vt[i].a1; a_vi1 = vt[i].d1; a_bmsk1 = vt[i].m1;
            @(negedge clk);
            chk("a_gnt0",   i, 32'(a_gnt0),   32'(vt[i].eg0));
            chk("a_gnt1",   i, 32'(a_gnt1),   32'(vt[i].eg1));
            chk("a_rvalid0", i, 32'(a_rv0),   32'(vt[i].ev0));
            chk("a_rvalid1", i, 32'(a_rv1),   32'(vt[i].ev1));
            chk("a_mem_we", i, 32'(a_mem_we), 32'(vt[i].ewe));
            if (vt[i].ev0) chk("a_vo0", i, a_vo0, vt[i].evo);
            if (vt[i].ev1) chk("a_vo1", i, a_vo1, vt[i].evo);
            @(posedge clk);
            #1;
        end
        a_req0 = 0; a_req1 = 0; a_rst = 0;

        // Hand sequence on DUT B: strict alternation with BURST_MAX=1
        b_rst = 1'b0;
        @(negedge clk);
        chk("b_rst_rvalid0", 0, 32'(b_rv0), 32'd0);
        chk("b_rst_rvalid1", 0, 32'(b_rv1), 32'd0);
        @(posedge clk); #1;

        b_req0 = 1; b_we0 = 1; b_ai0 = 15'h0001; b_vi0 = 32'h11110001; b_bmsk0 = 4'hF;
        @(negedge clk);
        chk("b_wr_gnt0", 0, 32'(b_gnt0), 32'd1);
        @(posedge clk); #1;
        b_req0 = 0; b_we0 = 0;
        b_req1 = 1; b_we1 = 1; b_ai1 = 15'h0002; b_vi1 = 32'h22220002; b_bmsk1 = 4'hF;
        @(negedge clk);
        chk("b_wr_gnt1", 0, 32'(b_gnt1), 32'd1);
        chk("b_wr_gnt0", 1, 32'(b_gnt0), 32'd0);
        @(posedge clk); #1;
        b_req1 = 0; b_we1 = 0;
        @(posedge clk); #1;

        b_req0 = 1; b_we0 = 0; b_ai0 = 15'h0001;
        b_req1 = 1; b_we1 = 0; b_ai1 = 15'h0002;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) begin
                b_req0 = 0;
                b_req1 = 0;
            end
            @(negedge clk);
            if (k < 8) begin
                chk("b_alt_gnt0", k, 32'(b_gnt0), (k % 2 == 0) ? 32'd1 : 32'd0);
                chk("b_alt_gnt1", k, 32'(b_gnt1), (k % 2 == 1) ? 32'd1 : 32'd0);
            end
            chk("b_alt_rvalid0", k, 32'(b_rv0), (k > 0 && (k - 1) % 2 == 0) ? 32'd1 : 32'd0);
            chk("b_alt_rvalid1", k, 32'(b_rv1), (k > 0 && (k - 1) % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0 && (k - 1) % 2 == 0) chk("b_alt_vo0", k, b_vo0, 32'h11110001);
            if (k > 0 && (k - 1) % 2 == 1) chk("b_alt_vo1", k, b_vo1, 32'h22220002);
            @(posedge clk); #1;
        end

        // A lone requester keeps the bus even with BURST_MAX=1
        b_req0 = 1; b_we0 = 0; b_ai0 = 15'h0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_lone_gnt0", k, 32'(b_gnt0), 32'd1);
            chk("b_lone_rvalid0", k, 32'(b_rv0), (k > 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        b_req0 = 0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/spram32_arb.md
# spram32_arb

Two-port round-robin arbiter for the 32-bit 32K-word single-port SPRAM bank. It lets the CPU data port (requester 0) and a second master such as instruction fetch or DMA (requester 1) share the bank's one address/data port. It grants at most one access per cycle and routes the single-cycle-latency read data back to the requester that issued the read. Bounded bursts prevent either requester from starving the other.

## Interface
- BURST_MAX, 4, maximum consecutive grants to one requester while the other is waiting; legal range 1..15.

Ports: one clock; reset is synchronous and active-high.
- clk  in  1  system clock, shared with the SPRAM bank
- rst  in  1  synchronous active-high reset
- req0 / req1  in  1  access request; held until granted
- we0 / we1  in  1  1 = write, 0 = read
- ai0 / ai1  in  15  word address; bit 14 selects the upper 16K bank pair
- vi0 / vi1  in  32  write data
- bmsk0 / bmsk1  in  4  byte-write mask; bit n enables byte n
- gnt0 / gnt1  out  1  combinational; the access is issued to memory this cycle
- rvalid0 / rvalid1  out  1  registered; read data is valid this cycle
- vo0 / vo1  out  32  read data (mem_vo fanned out); qualify with rvalid
- mem_ai  out  15  SPRAM address
- mem_vi  out  32  SPRAM write data
- mem_we  out  1  SPRAM write enable
- mem_bmsk  out  4  SPRAM byte mask
- mem_vo  in  32  SPRAM read data, valid one cycle after the address

## Operation
- Registers:
  - owner ∈ {NONE, R0, R1}
  - last ∈ {R0, R1}: most recently granted requester
  - cnt[3:0]: consecutive grants to the current owner, minus 1
  - rsel ∈ {NONE, R0, R1}: the pending read's destination
- Decision d, evaluated each cycle, first matching rule wins:
  1. owner ≠ NONE and req[owner]=1 and not (cnt = BURST_MAX-1 and req[other]=1) → d = owner
  2. req0 and req1 → d = other-than-last
  3. exactly one req → d = that requester
  4. otherwise → d = NONE
- Outputs:
  - gnt_d = 1, all other gnt = 0.
  - Memory port driven from requester d (ai, vi, we, bmsk).
  - d = NONE: mem_we=0, mem_bmsk=0, mem_ai=0, mem_vi=0.
- Register update (rising clk, rst=0):
  - owner ← d
  - last ← d if d ≠ NONE, else unchanged
  - cnt ← sat_inc(cnt) (saturating at BURST_MAX-1) if d = owner ≠ NONE, else 0
  - rsel ← d if d ≠ NONE and we_d = 0, else NONE
- Read return:
  - rvalid_x = (rsel = x).
  - vo0 = vo1 = mem_vo.
  - Writes produce no rvalid.
- The owner's state machine moves among NONE, R0 and R1 only via d:
  - a requester keeps ownership while it keeps requesting;
  - it yields after BURST_MAX grants if the other requester is waiting;
  - ownership drops to NONE on an idle cycle.
- BURST_MAX=1 gives strict alternation under contention.
- A requester must not change we/ai/vi/bmsk while req=1 and gnt=0.

## Timing
- Reset values:
  - gnt0 = gnt1 = 0 unless req is asserted; grant logic is live during reset, but the memory-side write is suppressed: mem_we = 0 while rst = 1.
  - rvalid0 = rvalid1 = 0; owner = NONE; last = R1, so R0 wins the first tie; cnt = 0; rsel = NONE.
- Grant latency: 0 cycles when the bus is free (gnt in the same cycle as req).
- Worst-case wait for a requesting port: BURST_MAX cycles.
- Read latency: rvalid exactly 1 cycle after gnt with we=0. Throughput is 1 access per cycle, and back-to-back reads from alternating requesters return in issue order.
- Write: committed at the gnt clock edge. A read of the same address in the next cycle returns the new data.
- Reset asserted mid-burst: the next edge clears owner, cnt and rsel. An outstanding read's rvalid is dropped, and the requester must re-issue.
- The owner deasserts req while the other is waiting: the other is granted in the same cycle, with no bubble.
- cnt saturates and never wraps. A lone requester keeps the bus indefinitely.

## Test plan
- Single read: after reset, write 0xDEADBEEF to 0x0005 via port 0 (bmsk=4'hF), then read 0x0005 via port 1 → gnt1 is immediate, rvalid1=1 on the next cycle with vo1=0xDEADBEEF, and rvalid0 stays 0.
- Byte mask: preload 0x11223344 at 0x4010 (upper bank), write 0xAABBCCDD with bmsk=4'b0101 → read returns 0x11BB33DD.
- Contention, BURST_MAX=4: both ports request continuous reads from reset → grant sequence is R0×4, R1×4, R0×4, and each rvalid matches its own gnt one cycle later.
- BURST_MAX=1 with both requesting → gnt alternates R0, R1, R0, R1 every cycle. Interleaved reads of 0x0001 (port 0) and 0x0002 (port 1) return the correct data to each port.
- Early release: port 1 owns the bus with cnt=1, then drops req while port 0 waits → gnt0 in the same cycle, cnt restarts at 0, with no idle cycle.
- Reset mid-read: port 0 read granted, rst=1 on the next edge → rvalid0=0 after that edge. mem_we=0 throughout reset, and a port-0 write request held during rst does not corrupt memory.
